// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the default widths, the zero-register number and the
// write-source encoding.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_NUM_BITWIDTH  = 5;
    localparam int unsigned WORD_BITWIDTH     = 32;
    // Wide enough for any MAX_WAIT in 1..15.
    localparam int unsigned WAIT_CNT_BITWIDTH = 4;
    localparam int unsigned REG_ZERO          = 0;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register
// file write port.
//   master: requester / register-file side (drives valid/rd/data, sees
//           ready and the registered write port)
//   slave : the arbiter (takes requests, drives ready and rf_*)
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned REG_NUM_BITWIDTH = wb_port_arbiter_pkg::REG_NUM_BITWIDTH,
    parameter int unsigned WORD_BITWIDTH    = wb_port_arbiter_pkg::WORD_BITWIDTH
);

    logic                        a_valid;
    logic                        a_ready;
    logic [REG_NUM_BITWIDTH-1:0] a_rd;
    logic [WORD_BITWIDTH-1:0]    a_data;

    logic                        b_valid;
    logic                        b_ready;
    logic [REG_NUM_BITWIDTH-1:0] b_rd;
    logic [WORD_BITWIDTH-1:0]    b_data;

    logic                        rf_we;
    logic [REG_NUM_BITWIDTH-1:0] rf_waddr;
    logic [WORD_BITWIDTH-1:0]    rf_wdata;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard for outstanding long-latency writes.
//   set_valid/set_rd : mark a destination busy (x0 ignored)
//   clr_valid/clr_rd : release a destination on its register-file write
//   chk_rs1/rs2/rd   : operands of the issuing instruction
//   stall            : some non-x0 operand is busy
//   busy             : current scoreboard bits
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned REG_NUM_BITWIDTH = wb_port_arbiter_pkg::REG_NUM_BITWIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_valid,
    input  logic [REG_NUM_BITWIDTH-1:0]    set_rd,
    input  logic                           clr_valid,
    input  logic [REG_NUM_BITWIDTH-1:0]    clr_rd,
    input  logic [REG_NUM_BITWIDTH-1:0]    chk_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0]    chk_rs2,
    input  logic [REG_NUM_BITWIDTH-1:0]    chk_rd,
    output logic                           stall,
    output logic [2**REG_NUM_BITWIDTH-1:0] busy
);

    localparam logic [REG_NUM_BITWIDTH-1:0] Zero = REG_NUM_BITWIDTH'(REG_ZERO);

    logic [2**REG_NUM_BITWIDTH-1:0] busy_q;
    logic [2**REG_NUM_BITWIDTH-1:0] busy_d;

    // Set is applied after clear so a same-edge collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_valid && (set_rd != Zero)) begin
            busy_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        stall = ((chk_rs1 != Zero) && busy_q[chk_rs1]) ||
                ((chk_rs2 != Zero) && busy_q[chk_rs2]) ||
                ((chk_rd  != Zero) && busy_q[chk_rd]);
    end

    assign busy = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority to the pipeline
// writeback (A) with a starvation guard for the long-latency unit (B),
// a registered write stage, and a busy scoreboard for B destinations.
//   clk, rst          : clock, async active-low reset
//   bus               : requester handshakes and registered rf write port
//   mark_valid/rd     : issue stage dispatching a B-type op
//   chk_rs1/rs2/rd    : operands of the issuing instruction
//   stall             : issuing instruction must hold
//   busy              : scoreboard bits
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned REG_NUM_BITWIDTH = wb_port_arbiter_pkg::REG_NUM_BITWIDTH,
    parameter int unsigned WORD_BITWIDTH    = wb_port_arbiter_pkg::WORD_BITWIDTH,
    parameter int unsigned MAX_WAIT         = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    wb_port_arbiter_if.slave               bus,
    input  logic                           mark_valid,
    input  logic [REG_NUM_BITWIDTH-1:0]    mark_rd,
    input  logic [REG_NUM_BITWIDTH-1:0]    chk_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0]    chk_rs2,
    input  logic [REG_NUM_BITWIDTH-1:0]    chk_rd,
    output logic                           stall,
    output logic [2**REG_NUM_BITWIDTH-1:0] busy
);

    localparam logic [REG_NUM_BITWIDTH-1:0]  Zero    = REG_NUM_BITWIDTH'(REG_ZERO);
    localparam logic [WAIT_CNT_BITWIDTH-1:0] WaitMax = WAIT_CNT_BITWIDTH'(MAX_WAIT);

    logic [WAIT_CNT_BITWIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                         rf_we_q;
    logic [REG_NUM_BITWIDTH-1:0]  rf_waddr_q;
    logic [WORD_BITWIDTH-1:0]     rf_wdata_q;
    src_e                         src_q;

    logic starve, a_ready, b_ready, a_hs, b_hs;

    // Ready is forced low while reset is asserted.
    always_comb begin
        starve  = bus.b_valid && (wait_cnt_q == WaitMax);
        a_ready = rst && bus.a_valid && !starve;
        b_ready = rst && bus.b_valid && !a_ready;
        a_hs    = bus.a_valid && a_ready;
        b_hs    = bus.b_valid && b_ready;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.b_valid || b_hs) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            src_q      <= SRC_A;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (a_hs) begin
                rf_we_q    <= (bus.a_rd != Zero);
                rf_waddr_q <= bus.a_rd;
                rf_wdata_q <= bus.a_data;
                src_q      <= SRC_A;
            end else if (b_hs) begin
                rf_we_q    <= (bus.b_rd != Zero);
                rf_waddr_q <= bus.b_rd;
                rf_wdata_q <= bus.b_data;
                src_q      <= SRC_B;
            end else begin
                rf_we_q <= 1'b0;
                src_q   <= SRC_A;
            end
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    // Busy clears on the same edge the register file takes the B write.
    wb_scoreboard #(
        .REG_NUM_BITWIDTH (REG_NUM_BITWIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (mark_valid),
        .set_rd    (mark_rd),
        .clr_valid (rf_we_q && (src_q == SRC_B)),
        .clr_rd    (rf_waddr_q),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .stall     (stall),
        .busy      (busy)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic [31:0] busy;

    int checks;
    int errors;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .REG_NUM_BITWIDTH (5),
        .WORD_BITWIDTH    (32),
        .MAX_WAIT         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mark_valid (mark_valid),
        .mark_rd    (mark_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .stall      (stall),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        mv;
        logic [4:0]  mrd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] ar;
        logic [31:0] br;
        logic [31:0] st;
        logic [31:0] we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] bz;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(
        int unsigned av, int unsigned ard, int unsigned ad,
        int unsigned bv, int unsigned brd, int unsigned bd,
        int unsigned mv, int unsigned mrd,
        int unsigned rs1, int unsigned rs2, int unsigned rd,
        int unsigned ar, int unsigned br, int unsigned st, int unsigned we,
        int unsigned wa, int unsigned wd, int unsigned bz);
        vec_t v;
        v.av  = 1'(av);
        v.ard = 5'(ard);
        v.ad  = ad;
        v.bv  = 1'(bv);
        v.brd = 5'(brd);
        v.bd  = bd;
        v.mv  = 1'(mv);
        v.mrd = 5'(mrd);
        v.rs1 = 5'(rs1);
        v.rs2 = 5'(rs2);
        v.rd  = 5'(rd);
        v.ar  = ar;
        v.br  = br;
        v.st  = st;
        v.we  = we;
        v.wa  = wa;
        v.wd  = wd;
        v.bz  = bz;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                         input logic mv, input logic [4:0] mrd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.a_valid = av;
        bus.a_rd    = ard;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_rd    = brd;
        bus.b_data  = bd;
        mark_valid  = mv;
        mark_rd     = mrd;
        chk_rs1     = rs1;
        chk_rs2     = rs2;
        chk_rd      = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // av ard ad  bv brd bd  mv mrd rs1 rs2 rd | ar br st we wa wd busy
        add_vec(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5, 32'hDEADBEEF, 0);
        // Contention: A wins four times, then B preempts.
        add_vec(1, 1, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0, 0,  1, 0, 0, 0, 5, 32'hDEADBEEF, 0);
        add_vec(1, 1, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h11, 0);
        add_vec(1, 1, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h11, 0);
        add_vec(1, 1, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h11, 0);
        add_vec(1, 1, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 32'h11, 0);
        // Wait count restarted after the B grant: A wins again.
        add_vec(1, 1, 32'h11, 1, 7, 32'h78, 0, 0, 0, 0, 0,  1, 0, 0, 1, 7, 32'h77, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 32'h11, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h11, 0);
        // Scoreboard mark, stall, B commit clears it.
        add_vec(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0,  0, 0, 0, 0, 1, 32'h11, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0,  0, 0, 1, 0, 1, 32'h11, 32'h200);
        add_vec(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0,  0, 1, 1, 0, 1, 32'h11, 32'h200);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0,  0, 0, 1, 1, 9, 32'h99, 32'h200);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0,  0, 0, 0, 0, 9, 32'h99, 0);
        // Set/clear collision on reg 9: set wins.
        add_vec(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0, 0, 0, 9, 32'h99, 0);
        add_vec(0, 0, 0, 1, 9, 32'h9A, 0, 0, 9, 0, 0,  0, 1, 1, 0, 9, 32'h99, 32'h200);
        add_vec(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9,  0, 0, 1, 1, 9, 32'h9A, 32'h200);
        add_vec(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 9,  0, 0, 1, 0, 9, 32'h9A, 32'h200);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0,  0, 0, 1, 0, 9, 32'h9A, 32'h208);
        // x0: handshake completes, no write, no busy change.
        add_vec(1, 0, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 9, 32'h9A, 32'h208);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h55, 32'h208);
        // Marking an already-busy register keeps it set.
        add_vec(0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0,  0, 0, 1, 0, 0, 32'h55, 32'h208);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h55, 32'h208);

        // Reset state with requests pending.
        drive(1, 5, 32'h1, 1, 6, 32'h2, 1, 4, 0, 0, 0);
        #1;
        check("rst a_ready", 32'(bus.a_ready), 32'd0);
        check("rst b_ready", 32'(bus.b_ready), 32'd0);
        check("rst rf_we", 32'(bus.rf_we), 32'd0);
        check("rst rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst rf_wdata", bus.rf_wdata, 32'd0);
        check("rst busy", busy, 32'd0);
        @(posedge clk);
        @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd,
                  vecs[i].mv, vecs[i].mrd, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            #1;
            check($sformatf("v%0d a_ready", i), 32'(bus.a_ready), vecs[i].ar);
            check($sformatf("v%0d b_ready", i), 32'(bus.b_ready), vecs[i].br);
            check($sformatf("v%0d stall", i), 32'(stall), vecs[i].st);
            check($sformatf("v%0d rf_we", i), 32'(bus.rf_we), vecs[i].we);
            check($sformatf("v%0d rf_waddr", i), 32'(bus.rf_waddr), vecs[i].wa);
            check($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vecs[i].wd);
            check($sformatf("v%0d busy", i), busy, vecs[i].bz);
            @(posedge clk);
            #1;
        end

        // Reset mid-operation: busy[3]/[9] set, wait count 2, rf_we high.
        drive(1, 4, 32'h44, 1, 3, 32'h33, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre rf_we", 32'(bus.rf_we), 32'd1);
        check("pre busy", busy, 32'h208);
        #2 rst = 1'b0;
        #1;
        check("async busy", busy, 32'd0);
        check("async rf_we", 32'(bus.rf_we), 32'd0);
        check("async rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("async rf_wdata", bus.rf_wdata, 32'd0);
        check("async a_ready", 32'(bus.a_ready), 32'd0);
        check("async b_ready", 32'(bus.b_ready), 32'd0);
        @(posedge clk);
        #1;
        check("held rf_we", 32'(bus.rf_we), 32'd0);
        check("held busy", busy, 32'd0);
        check("held a_ready", 32'(bus.a_ready), 32'd0);
        rst = 1'b1;
        #1;
        // Wait count must restart from 0: four A grants, then B.
        for (int k = 0; k < 5; k++) begin
            check($sformatf("post%0d a_ready", k), 32'(bus.a_ready), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("post%0d b_ready", k), 32'(bus.b_ready), (k == 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("post rf_waddr", 32'(bus.rf_waddr), 32'd3);
        check("post rf_wdata", bus.rf_wdata, 32'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Requester A: the in-order pipeline writeback stage.
  - Requester B: a long-latency unit (multiply/divide, load miss).
- Fixed priority to A, with a starvation guard for B.
- Keeps a per-register busy scoreboard for outstanding B operations and drives a stall to the issue stage.
- Sits between the writeback sources and the register file write inputs (write enable, write register number, write data).

Parameters:
- REG_NUM_BITWIDTH, 5, width of a register number; scoreboard has 2**REG_NUM_BITWIDTH bits.
- WORD_BITWIDTH, 32, data word width.
- MAX_WAIT, 4, cycles B may be refused before it preempts A (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- a_valid  input  1  A has a write pending.
- a_ready  output  1  A write accepted this cycle.
- a_rd  input  REG_NUM_BITWIDTH  A destination register.
- a_data  input  WORD_BITWIDTH  A write data.
- b_valid  input  1  B has a write pending.
- b_ready  output  1  B write accepted this cycle.
- b_rd  input  REG_NUM_BITWIDTH  B destination register.
- b_data  input  WORD_BITWIDTH  B write data.
- mark_valid  input  1  issue stage dispatches a B-type op this cycle.
- mark_rd  input  REG_NUM_BITWIDTH  destination of that op.
- chk_rs1  input  REG_NUM_BITWIDTH  issuing instruction source 1.
- chk_rs2  input  REG_NUM_BITWIDTH  issuing instruction source 2.
- chk_rd  input  REG_NUM_BITWIDTH  issuing instruction destination.
- stall  output  1  issuing instruction must hold.
- busy  output  2**REG_NUM_BITWIDTH  scoreboard bits, for debug and forwarding.
- rf_we  output  1  register file write enable (registered).
- rf_waddr  output  REG_NUM_BITWIDTH  register file write register (registered).
- rf_wdata  output  WORD_BITWIDTH  register file write data (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - busy=0, wait_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, src_b=0.
  - Writes in flight are dropped.
  - a_ready/b_ready are 0 while reset is asserted.
- Grant (combinational from current inputs and state):
  - starve = b_valid && wait_cnt==MAX_WAIT.
  - a_ready = a_valid && !starve.
  - b_ready = b_valid && !a_ready.
  - At most one ready per cycle.
- Handshake = valid && ready. Requesters hold valid/rd/data stable until their handshake; the arbiter does not check this.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each cycle with b_valid && !b_ready.
  - Clears to 0 on a B handshake or when b_valid=0.
- Write stage:
  - On the edge ending a handshake cycle: rf_waddr<=rd, rf_wdata<=data, rf_we<=(rd!=0), src_b<=(B granted).
  - Cycles with no handshake: rf_we<=0, src_b<=0, rf_waddr/rf_wdata hold.
  - Latency: handshake cycle N gives rf_we=1 in cycle N+1; the register file captures at the end of N+1.
- Register x0: handshake completes normally; rf_we stays 0 and busy is untouched.
- Scoreboard:
  - Set: busy[mark_rd]<=1 on mark_valid && mark_rd!=0.
  - Clear: busy[rf_waddr]<=0 on an edge where rf_we && src_b, i.e. the same edge the register file writes. A read after that edge sees the new value and busy=0.
  - Set and clear of the same bit on the same edge: set wins.
  - Marking an already-busy bit: stays 1.
  - A writes never touch busy.
- stall (combinational): (chk_rs1!=0 && busy[chk_rs1]) || (chk_rs2!=0 && busy[chk_rs2]) || (chk_rd!=0 && busy[chk_rd]).
  - The chk_rd term blocks WAW against pending B writes.
  - A mark in the current cycle is not reflected until the next cycle.
- Both requesters idle: no state change except wait_cnt clearing.

Decomposition:
- Shared package:
  - REG_NUM_BITWIDTH and WORD_BITWIDTH defaults.
  - Zero-register constant (REG_ZERO = 0).
  - Source enum (SRC_A, SRC_B).
- One sub-module, wb_scoreboard:
  - Holds the busy bit-vector with set/clear ports and priority.
  - Provides the three-source stall check.
- Arbiter, wait counter and write stage stay in the top module.

Test Plan:
- A only: a_valid=1, a_rd=5, a_data=0xDEADBEEF, b_valid=0 -> a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Contention: a_valid and b_valid held 1 (b_rd=7), MAX_WAIT=4 -> A granted 4 cycles; wait_cnt reaches 4; cycle 5 b_ready=1, a_ready=0; next cycle rf_waddr=7; wait_cnt returns to 0.
- Scoreboard: mark_valid, mark_rd=9 -> busy[9]=1 next cycle; chk_rs2=9 gives stall=1. B handshake with b_rd=9 -> busy[9] clears on the edge after rf_we=1; stall=0 afterwards.
- Set/clear collision: B commit to reg 9 on the same edge as mark_valid, mark_rd=9 -> busy[9] remains 1.
- x0: a_rd=0 and mark_rd=0 -> handshake completes, rf_we stays 0, busy stays 0, chk_rs1=0 gives stall=0.
- Reset mid-operation: busy[3]=1, wait_cnt=2, rf_we=1; pull rst low between edges -> busy=0, rf_we=0, wait_cnt=0 immediately; outputs stay 0 until rst returns high.
